// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : weight_loader
// Purpose  : Transmit side of the systolic-array weight-load protocol.
//            Collects one ROWS x COLS weight tile from the weight buffer over
//            a valid/ready stream, stages it, then shifts it into the PE
//            columns with a one-cycle skew per column, followed by the
//            per-column switch pulses that make the new tile live.
// Revision : 1.0 - initial release
//
// Build option:
//   WLOAD_AUTO_SWITCH_EN  defined   -> switch pulses follow the drive phase
//                                      automatically (skewed like accepts).
//                         undefined -> after driving, wait in ARMED until
//                                      switch_req, then pulse column c in the
//                                      c-th SWITCH cycle.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   start       in   one-cycle request to load a tile (ignored while busy)
//   wb_valid    in   weight-buffer beat valid
//   wb_ready    out  loader accepts a beat this cycle (FILL only)
//   wb_data     in   one tile row, lane c = [c*DATA_WIDTH +: DATA_WIDTH]
//   switch_req  in   external switch request (manual-switch build only)
//   col_weight  out  per-column weight into the top PE
//   col_accept  out  per-column accept-weight strobe
//   col_switch  out  per-column switch pulse into the top PE
//   busy        out  FSM is not IDLE
//   done        out  one-cycle pulse once the tile is live
// ============================================================================
module weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 2,
  parameter int COLS       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [COLS*DATA_WIDTH-1:0] wb_data,
  input  logic                       switch_req,
  output logic [COLS*DATA_WIDTH-1:0] col_weight,
  output logic [COLS-1:0]            col_accept,
  output logic [COLS-1:0]            col_switch,
  output logic                       busy,
  output logic                       done
);

  // One counter serves as beat index (FILL), skew step k (DRIVE/SWITCH) and
  // switch index (manual SWITCH); its largest value is ROWS+COLS-1.
  localparam int CW = $clog2(ROWS + COLS + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] c_fill_last  = CW'(ROWS - 1);
  localparam logic [CW-1:0] c_drive_last = CW'(ROWS + COLS - 2);
  localparam logic [CW-1:0] c_sw_last    = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_DRIVE  = 3'd2,
    S_ARMED  = 3'd3,
    S_SWITCH = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                     r_state;
  state_t                     w_state_n;
  logic [CW-1:0]              r_cnt;
  logic [CW-1:0]              w_cnt_n;
  logic [COLS*DATA_WIDTH-1:0] r_stage   [ROWS];
  logic [COLS*DATA_WIDTH-1:0] w_stage_n [ROWS];

  logic [COLS*DATA_WIDTH-1:0] w_weight_n;
  logic [COLS-1:0]            w_accept_n;
  logic [COLS-1:0]            w_switch_n;

  // --------------------------------------------------------------------------
  // Next-state, counter and staging-buffer update
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_stage_n = r_stage;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_FILL;
          w_cnt_n   = '0;
        end
      end

      S_FILL: begin
        if (wb_valid) begin
          w_stage_n[r_cnt[RW-1:0]] = wb_data;
          if (r_cnt == c_fill_last) begin
            w_state_n = S_DRIVE;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end

      S_DRIVE: begin
        if (r_cnt == c_drive_last) begin
`ifdef WLOAD_AUTO_SWITCH_EN
          // Keep counting: the last column's switch sits at k = ROWS+COLS-1.
          w_state_n = S_SWITCH;
          w_cnt_n   = r_cnt + 1'b1;
`else
          w_state_n = S_ARMED;
          w_cnt_n   = '0;
`endif
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end

      S_ARMED: begin
        if (switch_req) begin
          w_state_n = S_SWITCH;
          w_cnt_n   = '0;
        end
      end

      S_SWITCH: begin
`ifdef WLOAD_AUTO_SWITCH_EN
        w_state_n = S_DONE;
        w_cnt_n   = '0;
`else
        if (r_cnt == c_sw_last) begin
          w_state_n = S_DONE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
`endif
      end

      S_DONE: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end

      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from the *next* state so the registered outputs line up
  // with the state they describe. Decoding from the next staging contents
  // lets k=0 use the bottom row in the same edge it is captured.
  // --------------------------------------------------------------------------
  always_comb begin
    int             w_k;
    logic [RW-1:0]  w_row;

    w_weight_n = '0;
    w_accept_n = '0;
    w_switch_n = '0;
    w_row      = '0;
    w_k        = int'(w_cnt_n);

    for (int c = 0; c < COLS; c++) begin
      // Column c is shifting during k = c .. c+ROWS-1, bottom row first so
      // that after ROWS shifts PE row r holds stage[r][c].
      if ((w_state_n == S_DRIVE) && (w_k >= c) && (w_k < c + ROWS)) begin
        w_row         = RW'(ROWS - 1 - (w_k - c));
        w_accept_n[c] = 1'b1;
        w_weight_n[c*DATA_WIDTH +: DATA_WIDTH] =
          w_stage_n[w_row][c*DATA_WIDTH +: DATA_WIDTH];
      end

`ifdef WLOAD_AUTO_SWITCH_EN
      // Switch lands the cycle after the column's last accept; it may
      // overlap accepts of later columns.
      if (((w_state_n == S_DRIVE) || (w_state_n == S_SWITCH)) &&
          (w_k == c + ROWS)) begin
        w_switch_n[c] = 1'b1;
      end
`else
      if ((w_state_n == S_SWITCH) && (w_k == c)) begin
        w_switch_n[c] = 1'b1;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_stage[r] <= '0;
      end
      wb_ready   <= 1'b0;
      col_weight <= '0;
      col_accept <= '0;
      col_switch <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_stage    <= w_stage_n;
      wb_ready   <= (w_state_n == S_FILL);
      col_weight <= w_weight_n;
      col_accept <= w_accept_n;
      col_switch <= w_switch_n;
      busy       <= (w_state_n != S_IDLE);
      done       <= (w_state_n == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_loader
// Purpose  : Directed self-checking bench for weight_loader (ROWS=COLS=2).
//            Each cycle's observation is the packed vector
//            {wb_ready, col_weight, col_accept, col_switch, busy, done}.
//            Follows WLOAD_AUTO_SWITCH_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

  localparam int DW = 16;
  localparam int R  = 2;
  localparam int C  = 2;

  logic            clk        = 1'b0;
  logic            rst        = 1'b1;
  logic            start      = 1'b0;
  logic            wb_valid   = 1'b0;
  logic            switch_req = 1'b0;
  logic [C*DW-1:0] wb_data    = '0;
  logic            wb_ready;
  logic [C*DW-1:0] col_weight;
  logic [C-1:0]    col_accept;
  logic [C-1:0]    col_switch;
  logic            busy;
  logic            done;

  logic [38:0] obs;
  logic [38:0] exp_q [$];
  logic [38:0] obs_q [$];

  int checks = 0;
  int errors = 0;

  weight_loader #(
    .DATA_WIDTH(DW),
    .ROWS      (R),
    .COLS      (C)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .switch_req(switch_req),
    .col_weight(col_weight),
    .col_accept(col_accept),
    .col_switch(col_switch),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign obs = {wb_ready, col_weight, col_accept, col_switch, busy, done};

  function automatic logic [38:0] pk(input logic rdy, input logic [15:0] w1,
                                     input logic [15:0] w0, input logic [1:0] acc,
                                     input logic [1:0] sw, input logic bsy,
                                     input logic dn);
    return {rdy, w1, w0, acc, sw, bsy, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected timeline for one 2x2 load; sRC = tile row R, column C.
  // Cycle 0 carries start; FILL spans 2+bubbles cycles; DRIVE k=0..2.
  task automatic build_exp(input logic [15:0] s00, input logic [15:0] s01,
                           input logic [15:0] s10, input logic [15:0] s11,
                           input int bubbles, input int armed_wait,
                           input int tail_idle);
    exp_q.delete();
    exp_q.push_back(pk(1'b0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 2 + bubbles; i++)
      exp_q.push_back(pk(1'b1, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1, 1'b0));
    exp_q.push_back(pk(1'b0, 16'h0, s10, 2'b01, 2'b00, 1'b1, 1'b0));
    exp_q.push_back(pk(1'b0, s11, s00, 2'b11, 2'b00, 1'b1, 1'b0));
`ifdef WLOAD_AUTO_SWITCH_EN
    exp_q.push_back(pk(1'b0, s01, 16'h0, 2'b10, 2'b01, 1'b1, 1'b0));
    exp_q.push_back(pk(1'b0, 16'h0, 16'h0, 2'b00, 2'b10, 1'b1, 1'b0));
`else
    exp_q.push_back(pk(1'b0, s01, 16'h0, 2'b10, 2'b00, 1'b1, 1'b0));
    for (int i = 0; i < armed_wait + 1; i++)
      exp_q.push_back(pk(1'b0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1, 1'b0));
    exp_q.push_back(pk(1'b0, 16'h0, 16'h0, 2'b00, 2'b01, 1'b1, 1'b0));
    exp_q.push_back(pk(1'b0, 16'h0, 16'h0, 2'b00, 2'b10, 1'b1, 1'b0));
`endif
    exp_q.push_back(pk(1'b0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1, 1'b1));
    for (int i = 0; i < tail_idle; i++)
      exp_q.push_back(pk(1'b0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0, 1'b0));
  endtask

  // Drives one load for exp_q.size() cycles and records each cycle's outputs.
  // Junk beats are offered with valid=1 outside FILL and must be ignored.
  task automatic run_tile(input logic [31:0] r0, input logic [31:0] r1,
                          input int bubbles, input int armed_wait,
                          input int start_at);
    int b1;
    int req_at;
    b1     = 2 + bubbles;
    req_at = 6 + bubbles + armed_wait;
    obs_q.delete();
    for (int cyc = 0; cyc < exp_q.size(); cyc++) begin
      obs_q.push_back(obs);
      start      = (cyc == 0) || (cyc == start_at);
      switch_req = (cyc == req_at);
      if (cyc == 1) begin
        wb_valid = 1'b1; wb_data = r0;
      end else if (cyc == b1) begin
        wb_valid = 1'b1; wb_data = r1;
      end else if (cyc > 1 && cyc < b1) begin
        wb_valid = 1'b0; wb_data = 32'hDEAD_BEEF;
      end else begin
        wb_valid = 1'b1; wb_data = 32'hBAD0_BAD0;
      end
      tick();
    end
    start      = 1'b0;
    switch_req = 1'b0;
    wb_valid   = 1'b0;
    wb_data    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (obs !== 39'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs, 39'h0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 39'h0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected %h", obs, 39'h0);
    end
    // Load a tile and abort in the middle of DRIVE (k=1, both columns active).
    start = 1'b1;
    tick();
    start    = 1'b0;
    wb_valid = 1'b1;
    wb_data  = {16'h0200, 16'h0100};
    tick();
    wb_data  = {16'h0400, 16'h0300};
    tick();
    wb_valid = 1'b0;
    tick();
    checks++;
    if (col_accept !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_drive_setup: accept got %b expected %b", col_accept, 2'b11);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 39'h0) begin
      errors++;
      $display("FAIL reset_async_abort: got %h expected %h", obs, 39'h0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wb_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done cyc %0d: busy/done/ready got %b%b%b expected 000",
                 i, busy, done, wb_ready);
      end
    end
    // FSM must be back in IDLE: a fresh start enters FILL next cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (wb_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart: ready/busy got %b%b expected 11", wb_ready, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    build_exp(16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 5, 2);
    run_tile({16'h0200, 16'h0100}, {16'h0400, 16'h0300}, 0, 5, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_load cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fill_backpressure();
    build_exp(16'h0100, 16'h0200, 16'h0300, 16'h0400, 3, 2, 2);
    run_tile({16'h0200, 16'h0100}, {16'h0400, 16'h0300}, 3, 2, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fill_backpressure cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    // Start re-pulsed at cycle 4 (DRIVE k=1); tail must stay idle.
    build_exp(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 1, 4);
    run_tile({16'h2222, 16'h1111}, {16'h4444, 16'h3333}, 0, 1, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL start_while_busy cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_negative_weights();
    build_exp(16'hFFF0, 16'h8001, 16'hFFFF, 16'h0001, 0, 0, 1);
    run_tile({16'h8001, 16'hFFF0}, {16'h0001, 16'hFFFF}, 0, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL negative_weights cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_fill_backpressure();
    test_start_while_busy();
    test_negative_weights();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Transmit side of the systolic-array weight-load protocol.
- Collects one ROWS x COLS weight tile from the weight buffer over a valid/ready stream and stages it internally.
- Drives each array column's top-row weight, accept-weight and switch inputs with the per-column one-cycle skew the PE chain requires.
- Sits between the unified/weight buffer and the top row of the PE array.

Parameters:
DATA_WIDTH, 16, width of one signed fixed-point weight
ROWS, 2, PE rows per column (weights shifted down per column)
COLS, 2, PE columns driven (one lane each)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse: begin loading a tile; ignored while busy
wb_valid  input  1  weight-buffer beat valid
wb_ready  output  1  loader accepts beat this cycle
wb_data  input  COLS*DATA_WIDTH  one tile row; lane c = bits [c*DATA_WIDTH +: DATA_WIDTH]
switch_req  input  1  external switch request (used only without WLOAD_AUTO_SWITCH_EN)
col_weight  output  COLS*DATA_WIDTH  to top PE weight input of each column
col_accept  output  COLS  to accept-weight input of every PE in column c
col_switch  output  COLS  to top PE switch input of column c
busy  output  1  high whenever FSM is not IDLE
done  output  1  one-cycle pulse when the tile is live in the array

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all of these are 0: counters, staging buffer, wb_ready, col_weight, col_accept, col_switch, busy, done.
- All outputs are registered.
- States: IDLE -> FILL -> DRIVE -> (ARMED) -> SWITCH -> DONE -> IDLE.
- IDLE:
  - start=1 -> FILL next cycle.
  - start while busy=1 has no effect.
- FILL:
  - wb_ready=1.
  - Beat n (n=0..ROWS-1, in arrival order) is tile row n, written into stage[n] on wb_valid&&wb_ready.
  - wb_valid low: hold; bubbles are allowed.
  - After beat ROWS-1 is captured, wb_ready=0 next cycle and FSM enters DRIVE.
- DRIVE: counter k runs 0..ROWS+COLS-2, one step per cycle, no stalls.
  - Column c is active when c <= k < c+ROWS.
  - Active column: col_accept[c]=1 and lane c = stage[ROWS-1-(k-c)][c], i.e. bottom row sent first, so PE row r ends holding stage[r][c].
  - Inactive column: col_accept[c]=0, lane c = 0.
  - Once started, accept must be contiguous for ROWS cycles per column; any gap corrupts the PE shift chain.
- SWITCH: for column c, col_switch[c]=1 for exactly one cycle, the cycle after its last accept (k = c+ROWS in the extended count).
  - The pulse propagates down the PE switch chain after every row has latched its final weight.
  - Switch pulses may overlap accepts of later columns.
- DONE: done=1 for one cycle, the cycle after the last column's switch pulse; then IDLE.
- Latency, no FILL bubbles, auto switch: start -> done = 1 + ROWS + (ROWS+COLS) + 1 cycles.
  - Example ROWS=COLS=2: 8 cycles.
- Reset mid-operation: immediate abort. Outputs go to 0, staging is discarded, no done pulse.
  - A partially loaded array is the requester's responsibility.
- wb_data arriving outside FILL is not consumed (wb_ready=0).

Optional Feature:
- Macro WLOAD_AUTO_SWITCH_EN.
- Defined: SWITCH follows DRIVE automatically, as above.
- Undefined: after DRIVE the FSM enters ARMED, holding all outputs 0 and busy=1, until switch_req=1.
  - SWITCH then starts next cycle, with col_switch[c] pulsed in the c-th cycle of SWITCH.
  - DONE follows the last pulse.
  - This lets the controller swap weights only after the previous tile's inputs have drained.

Test Plan:
- Reset: rst=1 mid-DRIVE, ROWS=COLS=2 -> all outputs 0 in the same cycle; FSM in IDLE after release; no done pulse.
- Basic load, ROWS=COLS=2, auto:
  - beats {c1=0x0200,c0=0x0100} then {c1=0x0400,c0=0x0300}.
  - Expect col0 to present 0x0300, 0x0100 with accept on k=0,1.
  - Expect col1 to present 0x0400, 0x0200 with accept on k=1,2.
  - Expect switch[0] at k=2, switch[1] at k=3, done 1 cycle later.
  - Wired to a 2x2 PE array, PE[r][c] active weight = stage[r][c].
- FILL backpressure: wb_valid low 3 cycles between the two beats -> wb_ready stays 1; DRIVE timing and values are identical to the basic load, only shifted.
- start while busy: pulse start during DRIVE -> ignored; exactly one done pulse.
- Without WLOAD_AUTO_SWITCH_EN: hold switch_req=0 for 5 cycles after DRIVE -> col_switch stays 0 and busy=1; switch_req=1 -> switch[0] next cycle, switch[1] the cycle after, then done.
- Negative weights: lane value 0xFFF0 -> passed bit-exact to col_weight, with no sign or width alteration.
